// File: rtl/mul_operand_feeder.sv
// rtl/mul_operand_feeder.sv - operand-pair queue and sequencer feeding a shift-add multiplier controller (optional FEEDER_TIMEOUT_EN done-wait timeout)
module mul_operand_feeder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 70000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        start,
    output logic [15:0] data_in,
    input  logic        done,
    input  logic [15:0] y_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_y,
    output logic        out_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t        state;
    logic [15:0]   mem_a [FIFO_DEPTH];
    logic [15:0]   mem_b [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   op_a;
    logic [15:0]   op_b;
    logic          push;
    logic          pop;

    // Fullness comes only from the registered count, so a same-cycle pop never
    // widens the acceptance window; the queue depth is the hard limit.
    assign in_ready = (count != CW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && (count != '0);

`ifdef FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
`else
    assign out_err = 1'b0;
`endif

    // Operand-pair queue: pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_a[wr_ptr] <= in_a;
                mem_b[wr_ptr] <= in_b;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Sequencer: every output is registered and set on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            start     <= 1'b0;
            data_in   <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            op_a      <= '0;
            op_b      <= '0;
`ifdef FEEDER_TIMEOUT_EN
            out_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            start   <= 1'b0;
            data_in <= '0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        op_a  <= mem_a[rd_ptr];
                        op_b  <= mem_b[rd_ptr];
                        start <= 1'b1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    data_in <= op_a;
                    state   <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    data_in <= op_b;
                    state   <= S_LOAD_B;
                end
                S_LOAD_B: begin
`ifdef FEEDER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        out_y     <= y_in;
                        out_valid <= 1'b1;
`ifdef FEEDER_TIMEOUT_EN
                        out_err   <= 1'b0;
`endif
                        state     <= S_RESULT;
                    end
`ifdef FEEDER_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        out_y     <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_RESULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mul_operand_feeder.md
MUL_OPERAND_FEEDER -- requirements
Module: mul_operand_feeder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, operand-pair queue depth; power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 70000, done-wait limit in cycles; used only with FEEDER_TIMEOUT_EN.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  queue can accept a pair (not full).
REQ-007 in_a  input  16  multiplicand.
REQ-008 in_b  input  16  multiplier (repeat count).
REQ-009 start  output  1  start pulse to the multiplier controller.
REQ-010 data_in  output  16  operand bus to the multiplier datapath.
REQ-011 done  input  1  multiplier controller completion.
REQ-012 y_in  input  16  multiplier product register.
REQ-013 out_valid  output  1  product held for downstream.
REQ-014 out_ready  input  1  downstream accepts the product.
REQ-015 out_y  output  16  captured product.
REQ-016 out_err  output  1  product was aborted by timeout.

Function
REQ-017 Push SHALL occur on a cycle with in_valid && in_ready; in_ready SHALL be 0 exactly when the queue holds FIFO_DEPTH pairs.
REQ-018 Pointers SHALL wrap modulo FIFO_DEPTH; order SHALL be FIFO.
REQ-019 FSM states SHALL be IDLE, START, LOAD_A, LOAD_B, WAIT, RESULT.
REQ-020 IDLE: if queue non-empty, pop the head pair into internal registers -> START; else stay.
REQ-021 START: start=1 for exactly this one cycle, data_in=0 -> LOAD_A.
REQ-022 LOAD_A: data_in=A for one cycle -> LOAD_B.
REQ-023 LOAD_B: data_in=B for one cycle -> WAIT.
REQ-024 WAIT: data_in=0; on done=1, capture y_in into out_y, set out_err=0 -> RESULT.
REQ-025 RESULT: out_valid=1, out_y and out_err held stable; on out_ready=1 -> IDLE next cycle.
REQ-026 Latency from a pop to start SHALL be 1 cycle; from done to out_valid SHALL be 1 cycle.
REQ-027 A push on the same cycle as a pop SHALL be accepted when the queue is not full before the pop; in_ready SHALL NOT depend combinationally on pop.
REQ-028 Push into an empty queue SHALL be poppable no earlier than the following cycle.
REQ-029 done=1 in any state other than WAIT SHALL be ignored.
REQ-030 Operands of zero SHALL be forwarded unmodified; the product is whatever y_in holds at done.
REQ-031 start SHALL be 0 and data_in SHALL be 0 in all states except as stated in REQ-021..023.

Reset
REQ-032 rst=1 on a clock edge SHALL force IDLE, empty the queue, and set start=0, data_in=0, out_valid=0, out_y=0, out_err=0, in_ready=1.
REQ-033 Reset mid-operation (any state) SHALL discard the in-flight pair and all queued pairs without a product being emitted.
REQ-034 Push attempted during rst=1 SHALL be dropped.

Configuration
REQ-035 Macro FEEDER_TIMEOUT_EN defined: a counter SHALL clear on WAIT entry and increment each WAIT cycle; reaching TIMEOUT_CYCLES without done SHALL set out_y=0, out_err=1 and enter RESULT.
REQ-036 Macro FEEDER_TIMEOUT_EN undefined: no counter; WAIT SHALL persist until done; out_err SHALL be constant 0.

Verification
REQ-037 Reset, push (A=282, B=1) -> start at pop+1, data_in 282 then 1, y_in=282 at done -> out_valid with out_y=282, out_err=0.
REQ-038 Push 5 pairs with FIFO_DEPTH=4 and the FSM held in WAIT -> in_ready=0 after the 4th push, 5th refused; products emitted in push order.
REQ-039 Hold out_ready=0 for 10 cycles in RESULT -> out_valid and out_y stable; no new start until the cycle after out_ready=1.
REQ-040 Assert rst during LOAD_B with 2 queued pairs -> next cycle IDLE, in_ready=1, start=0, and no out_valid thereafter.
REQ-041 FEEDER_TIMEOUT_EN with TIMEOUT_CYCLES=20 and done held 0 -> out_valid after 20 WAIT cycles, out_err=1, out_y=0.
REQ-042 Pulse done in IDLE and LOAD_A -> no capture; a later done in WAIT -> normal capture.
